// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and defaults for the configurable SPI master, the loopback
//   slave and the bench.
//   - spi_state_e : master FSM states
//   - spi_mode_t  : per-transfer clock mode {cpol, cpha}
//   - SPI_DATA_W / SPI_CLK_DIV : default word width and sclk half-period
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int SPI_DATA_W  = 12;
    localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_edge_gen.sv
// -----------------------------------------------------------------------------
// spi_edge_gen
//   Timebase for the SPI master. Counts clk cycles inside each sclk
//   half-period and counts the sclk edges produced so far.
//
//   Ports
//     clk, rst    : system clock, synchronous active-low reset
//     run         : high while a transfer occupies SETUP/XFER/HOLD; when low
//                   both counters sit at zero
//     edge_en     : high in SETUP/XFER; a half-period boundary then produces
//                   an sclk edge (the SETUP boundary produces edge 1)
//     phase_end   : last clk cycle of the current half-period
//     lead_stb    : the boundary produces an odd (leading) sclk edge
//     trail_stb   : the boundary produces an even (trailing) sclk edge
//     last_edge   : the boundary produces edge 2*DATA_W (final trailing edge)
// -----------------------------------------------------------------------------
module spi_edge_gen
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic edge_en,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge,
    output logic phase_end
);

    // A divider of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] LAST_IDX = EDGE_W'(2 * DATA_W - 1);

    logic [HALF_W-1:0] half_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              edge_stb;

    assign phase_end = run && (half_cnt == HALF_MAX);
    assign edge_stb  = phase_end && edge_en;

    // edge_cnt holds the number of edges already produced, so an even count
    // means the edge about to be produced is odd, i.e. a leading edge.
    assign lead_stb  = edge_stb && !edge_cnt[0];
    assign trail_stb = edge_stb &&  edge_cnt[0];
    assign last_edge = trail_stb && (edge_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            half_cnt <= '0;
            edge_cnt <= '0;
        end else if (!run) begin
            half_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            if (phase_end) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
            if (edge_stb) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
//   Full-duplex SPI master with per-transfer cpol/cpha, programmable sclk
//   divider and selectable bit order. Each transfer shifts DATA_W bits out on
//   mosi while capturing DATA_W bits from miso.
//
//   Ports
//     clk, rst   : system clock, synchronous active-low reset
//     newd       : start request, only looked at in IDLE
//     din        : transmit word, captured with the accepted newd
//     cpol, cpha : clock mode, captured with the accepted newd
//     miso       : serial data from the slave
//     sclk, cs, mosi : SPI pins, all registered
//     dout       : received word, reloaded only when done pulses
//     done       : one-cycle completion pulse
//     busy       : high from the accepted newd until done
//     state_dbg  : current FSM state, for observation only
//
//   Handshake: a request is accepted on a rising clk edge where state is IDLE
//   and newd is 1; busy is the "not ready" indication and stays high for the
//   whole transfer. newd while busy or in DONE is dropped, never queued, so a
//   held newd restarts no sooner than two cycles after done.
// -----------------------------------------------------------------------------
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_W    = SPI_DATA_W,
    parameter int CLK_DIV   = SPI_CLK_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
    output spi_state_e        state_dbg
);

    spi_state_e        state;
    spi_state_e        next_state;
    spi_mode_t         mode_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    logic accept;
    logic edge_en;
    logic cs_d;
    logic lead_stb;
    logic trail_stb;
    logic last_edge;
    logic phase_end;
    logic sample_stb;
    logic shift_stb;

    // Bit-order helpers: the head of the word goes out first, received bits
    // enter at the opposite end so the word is aligned after DATA_W samples.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic              b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign accept    = (state == IDLE) && newd;
    assign state_dbg = state;

    spi_edge_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_edge_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (busy),
        .edge_en   (edge_en),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge),
        .phase_end (phase_end)
    );

    // cpha=0: the first bit is already on mosi from SETUP, so leading edges
    // sample and trailing edges shift, except the final trailing edge which
    // has no bit left to present. cpha=1: leading edges shift, trailing
    // edges sample.
    assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
    assign shift_stb  = mode_q.cpha ? lead_stb  : (trail_stb && !last_edge);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (newd)      next_state = SETUP;
            SETUP:   if (phase_end) next_state = XFER;
            XFER:    if (last_edge) next_state = HOLD;
            HOLD:    if (phase_end) next_state = DONE;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        done    = 1'b0;
        busy    = 1'b0;
        edge_en = 1'b0;
        unique case (state)
            SETUP, XFER: begin
                busy    = 1'b1;
                edge_en = 1'b1;
            end
            HOLD:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        // cs is registered from the next state so it lines up with state.
        cs_d = !(next_state inside {SETUP, XFER, HOLD});
    end

    // ------------------------------------------------------ datapath / pins
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
            sclk   <= 1'b0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
            dout   <= '0;
        end else begin
            cs <= cs_d;

            if (accept) begin
                mode_q.cpol <= cpol;
                mode_q.cpha <= cpha;
                if (!cpha) begin
                    mosi  <= head_bit(din);
                    tx_sr <= shift_out(din);
                end else begin
                    mosi  <= 1'b0;
                    tx_sr <= din;
                end
            end else if (shift_stb) begin
                mosi  <= head_bit(tx_sr);
                tx_sr <= shift_out(tx_sr);
            end else if (state == DONE) begin
                mosi <= 1'b0;
            end

            if (accept) begin
                rx_sr <= '0;
            end else if (sample_stb) begin
                rx_sr <= shift_in(rx_sr, miso);
            end

            // Idle level tracks the live cpol input; once a transfer starts
            // only the strobes move sclk, and the final trailing edge brings
            // it back to the latched idle level.
            if (state == IDLE) begin
                sclk <= cpol;
            end else if (lead_stb || trail_stb) begin
                sclk <= !sclk;
            end

            if ((state == HOLD) && phase_end) begin
                dout <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_master_cfg
//   Five master instances with different DATA_W/CLK_DIV/MSB_FIRST share one
//   stimulus set; sel routes newd to one instance and muxes its outputs to
//   the checker. A behavioural slave (or a miso=mosi loopback) answers, and
//   expected words and edge timing come from closed-form transfer rules.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;
    import spi_pkg::*;

    localparam int N = 5;
    localparam int DW_T  [N] = '{12, 8, 12, 2, 5};
    localparam int CD_T  [N] = '{ 4, 2,  4, 1, 3};
    localparam int MSB_T [N] = '{ 1, 1,  0, 1, 0};

    // ------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------ stimulus / muxing
    logic        newd     = 1'b0;
    logic [2:0]  sel      = 3'd0;
    logic [31:0] din_v    = '0;
    logic        cpol_v   = 1'b0;
    logic        cpha_v   = 1'b0;
    logic        miso_v   = 1'b0;
    logic        loopback = 1'b0;

    logic [N-1:0] sclk_w, cs_w, mosi_w, done_w, busy_w;
    logic [11:0]  dout0;
    logic [7:0]   dout1;
    logic [11:0]  dout2;
    logic [1:0]   dout3;
    logic [4:0]   dout4;
    spi_state_e   st0, st1, st2, st3, st4;

    logic        sclk_m, cs_m, mosi_m, done_m, busy_m, miso_w;
    logic [31:0] dout_m;
    spi_state_e  st_m;

    int checks = 0;
    int errors = 0;

    assign miso_w = loopback ? mosi_m : miso_v;

    always_comb begin
        sclk_m = sclk_w[sel];
        cs_m   = cs_w[sel];
        mosi_m = mosi_w[sel];
        done_m = done_w[sel];
        busy_m = busy_w[sel];
        dout_m = '0;
        st_m   = IDLE;
        case (sel)
            3'd0: begin dout_m = 32'(dout0); st_m = st0; end
            3'd1: begin dout_m = 32'(dout1); st_m = st1; end
            3'd2: begin dout_m = 32'(dout2); st_m = st2; end
            3'd3: begin dout_m = 32'(dout3); st_m = st3; end
            default: begin dout_m = 32'(dout4); st_m = st4; end
        endcase
    end

    spi_master_cfg #(.DATA_W(12), .CLK_DIV(4), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst(rst), .newd(newd && (sel == 3'd0)), .din(din_v[11:0]),
        .cpol(cpol_v), .cpha(cpha_v), .miso(miso_w), .sclk(sclk_w[0]), .cs(cs_w[0]),
        .mosi(mosi_w[0]), .dout(dout0), .done(done_w[0]), .busy(busy_w[0]), .state_dbg(st0));

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .newd(newd && (sel == 3'd1)), .din(din_v[7:0]),
        .cpol(cpol_v), .cpha(cpha_v), .miso(miso_w), .sclk(sclk_w[1]), .cs(cs_w[1]),
        .mosi(mosi_w[1]), .dout(dout1), .done(done_w[1]), .busy(busy_w[1]), .state_dbg(st1));

    spi_master_cfg #(.DATA_W(12), .CLK_DIV(4), .MSB_FIRST(0)) u_dut2 (
        .clk(clk), .rst(rst), .newd(newd && (sel == 3'd2)), .din(din_v[11:0]),
        .cpol(cpol_v), .cpha(cpha_v), .miso(miso_w), .sclk(sclk_w[2]), .cs(cs_w[2]),
        .mosi(mosi_w[2]), .dout(dout2), .done(done_w[2]), .busy(busy_w[2]), .state_dbg(st2));

    spi_master_cfg #(.DATA_W(2), .CLK_DIV(1), .MSB_FIRST(1)) u_dut3 (
        .clk(clk), .rst(rst), .newd(newd && (sel == 3'd3)), .din(din_v[1:0]),
        .cpol(cpol_v), .cpha(cpha_v), .miso(miso_w), .sclk(sclk_w[3]), .cs(cs_w[3]),
        .mosi(mosi_w[3]), .dout(dout3), .done(done_w[3]), .busy(busy_w[3]), .state_dbg(st3));

    spi_master_cfg #(.DATA_W(5), .CLK_DIV(3), .MSB_FIRST(0)) u_dut4 (
        .clk(clk), .rst(rst), .newd(newd && (sel == 3'd4)), .din(din_v[4:0]),
        .cpol(cpol_v), .cpha(cpha_v), .miso(miso_w), .sclk(sclk_w[4]), .cs(cs_w[4]),
        .mosi(mosi_w[4]), .dout(dout4), .done(done_w[4]), .busy(busy_w[4]), .state_dbg(st4));

    // ------------------------------------------------ scoreboard helpers
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position in the word of the i-th bit on the wire.
    function automatic int pos(input int i, input int dw, input int msb);
        return (msb != 0) ? (dw - 1 - i) : i;
    endfunction

    // One transfer (two when twice=1, the second started by newd held high
    // from cycle 29 through done with din changed to tx2 mid-transfer).
    // rst_at>0 pulls reset at that cycle and expects the transfer to vanish.
    // Cycle n counts rising clk edges after newd is driven; edge 1 accepts.
    task automatic run_xfer(input int id, input logic [31:0] tx, input logic [31:0] sw,
                            input logic cp, input logic ph, input logic lb,
                            input int rst_at, input bit twice, input logic [31:0] tx2);
        int dw, cd, msb, n, rises, toggles, first_tog, last_tog;
        int done_cycles, d1, d2, start_n, tx_i, rx_i, p;
        logic [31:0] mask, tx_m, tx2_m, sw_m, exp_tx, slave_rx;
        logic prev_sclk, prev_cs, mosi_first, got_first;
        string pfx;

        dw = DW_T[id];
        cd = CD_T[id];
        msb = MSB_T[id];
        mask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        tx_m = tx & mask;
        tx2_m = tx2 & mask;
        sw_m = sw & mask;
        pfx = $sformatf("id%0d m%0d%0d", id, cp, ph);
        n = 0; rises = 0; toggles = 0; first_tog = -1; last_tog = -1;
        done_cycles = 0; d1 = 0; d2 = 0; start_n = 0; tx_i = 0; rx_i = 0;
        slave_rx = '0; mosi_first = 1'b0; got_first = 1'b0;

        sel = 3'(id);
        cpol_v = cp;
        cpha_v = ph;
        loopback = lb;
        din_v = tx_m;
        @(negedge clk);
        @(negedge clk);
        check({pfx, " idle_sclk"}, 32'(sclk_m), 32'(cp));
        check({pfx, " idle_cs"}, 32'(cs_m), 32'd1);

        prev_sclk = sclk_m;
        prev_cs = cs_m;
        newd = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) newd = 1'b0;
            if (twice && n == 20) din_v = tx2_m;
            if (twice && n == 29) newd = 1'b1;
            if (twice && d1 > 0 && n == d1 + 2) newd = 1'b0;

            if (rst_at > 0 && n == rst_at - 1) rst = 1'b0;
            if (rst_at > 0 && n == rst_at) begin
                check({pfx, " rst_cs"}, 32'(cs_m), 32'd1);
                check({pfx, " rst_sclk"}, 32'(sclk_m), 32'd0);
                check({pfx, " rst_busy"}, 32'(busy_m), 32'd0);
                check({pfx, " rst_dout"}, dout_m, 32'd0);
                check({pfx, " rst_state"}, 32'(st_m), 32'(IDLE));
                rst = 1'b1;
            end

            // behavioural slave: restart on cs fall, react to sclk edges
            if (prev_cs && !cs_m) begin
                start_n = n;
                check({pfx, " cs_fall_time"}, 32'(n), (done_cycles == 0) ? 32'd1 : 32'(d1 + 2));
                check({pfx, " busy_rise"}, 32'(busy_m), 32'd1);
                rises = 0; toggles = 0; first_tog = -1; last_tog = -1;
                tx_i = 0; rx_i = 0; slave_rx = '0; got_first = 1'b0;
                if (!ph) begin
                    miso_v = sw_m[pos(0, dw, msb)];
                    tx_i = 1;
                end
            end
            if (!cs_m && sclk_m != prev_sclk) begin
                toggles++;
                if (first_tog < 0) first_tog = n;
                last_tog = n;
                if (sclk_m && !prev_sclk) rises++;
                if ((sclk_m != cp) == (ph == 1'b0)) begin
                    if (!got_first) begin
                        mosi_first = mosi_m;
                        got_first = 1'b1;
                    end
                    if (rx_i < dw) begin
                        p = pos(rx_i, dw, msb);
                        slave_rx[p] = mosi_m;
                    end
                    rx_i++;
                end else if (tx_i < dw) begin
                    miso_v = sw_m[pos(tx_i, dw, msb)];
                    tx_i++;
                end
            end

            if (done_m) begin
                done_cycles++;
                exp_tx = (done_cycles == 1) ? tx_m : tx2_m;
                check({pfx, " done_time"}, 32'(n), 32'(start_n + (2 * dw + 1) * cd));
                check({pfx, " dout"}, dout_m, lb ? exp_tx : sw_m);
                check({pfx, " slave_rx"}, slave_rx, exp_tx);
                check({pfx, " first_mosi"}, 32'(mosi_first), 32'(exp_tx[pos(0, dw, msb)]));
                check({pfx, " sclk_rises"}, 32'(rises), 32'(dw));
                check({pfx, " sclk_toggles"}, 32'(toggles), 32'(2 * dw));
                check({pfx, " first_edge"}, 32'(first_tog), 32'(start_n + cd));
                check({pfx, " last_edge"}, 32'(last_tog), 32'(start_n + 2 * dw * cd));
                check({pfx, " done_cs"}, 32'(cs_m), 32'd1);
                check({pfx, " done_busy"}, 32'(busy_m), 32'd0);
                check({pfx, " done_state"}, 32'(st_m), 32'(DONE));
                if (done_cycles == 1) d1 = n; else d2 = n;
            end

            prev_sclk = sclk_m;
            prev_cs = cs_m;

            if (rst_at > 0 && n == rst_at + 150) break;
            if (rst_at == 0 && !twice && d1 > 0 && n == d1 + 3) break;
            if (rst_at == 0 && twice && d2 > 0 && n == d2 + 3) break;
            if (n >= 1500) begin
                check({pfx, " timeout"}, 32'(n), 32'd0);
                break;
            end
        end
        newd = 1'b0;
        rst = 1'b1;

        check({pfx, " done_count"}, 32'(done_cycles),
              (rst_at > 0) ? 32'd0 : (twice ? 32'd2 : 32'd1));
        check({pfx, " end_sclk"}, 32'(sclk_m), 32'(cp));
        check({pfx, " end_cs"}, 32'(cs_m), 32'd1);
        check({pfx, " end_mosi"}, 32'(mosi_m), 32'd0);
    endtask

    // ------------------------------------------------ directed + random steps
    initial begin
        int id;
        // reset state of every instance, cpol=1 to show reset forces sclk=0
        rst = 1'b0;
        cpol_v = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            sel = 3'(i);
            #1;
            check($sformatf("reset%0d cs", i), 32'(cs_m), 32'd1);
            check($sformatf("reset%0d sclk", i), 32'(sclk_m), 32'd0);
            check($sformatf("reset%0d mosi", i), 32'(mosi_m), 32'd0);
            check($sformatf("reset%0d done", i), 32'(done_m), 32'd0);
            check($sformatf("reset%0d busy", i), 32'(busy_m), 32'd0);
            check($sformatf("reset%0d dout", i), dout_m, 32'd0);
            check($sformatf("reset%0d state", i), 32'(st_m), 32'(IDLE));
        end
        @(negedge clk);
        rst = 1'b1;

        // mode 0 loopback, defaults: done 101 cycles after newd
        run_xfer(0, 32'hA5C, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0);

        // all four modes against a slave returning 8'h3C
        for (int m = 0; m < 4; m++) begin
            run_xfer(1, 32'hC3, 32'h3C, m[1], m[0], 1'b0, 0, 1'b0, 32'h0);
        end

        // LSB first: only the first bit on the wire is 1
        run_xfer(2, 32'h001, 32'h5A3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);

        // newd held from cycle 29 through done, din changed mid-transfer
        run_xfer(0, 32'h3B7, 32'hC18, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h64E);

        // reset at cycle 40 aborts the transfer, dout was nonzero before
        run_xfer(0, 32'h777, 32'h999, 1'b0, 1'b0, 1'b0, 40, 1'b0, 32'h0);

        // DATA_W=2, CLK_DIV=1: done at cycle 6, sclk toggles every cycle
        run_xfer(3, 32'h2, 32'h1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);

        // randomized transfers across all instances and modes
        for (int r = 0; r < 16; r++) begin
            id = $urandom_range(0, N - 1);
            run_xfer(id, $urandom, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
